vpu_fp_reduce_ctrl: RTL and testbench
=====================================

# vpu_fp_reduce_ctrl

Sequencer that time-shares one combinational FP_ADD_SUB instance to reduce a stream of floating-point elements into a single result. It serves reduction commands (sum, or first-minus-rest) issued by VPU_CONTROLLER. It pulls one element per cycle from the source port over valid/ready and returns one result per command to VPU_DST_PORT.

## Interface
Parameters:
- OPERAND_WIDTH, default VPU_PKG::OPERAND_WIDTH: element and result width.
- LEN_W, default 8: width of the element count; maximum count is 2^LEN_W-1.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_len  in  LEN_W  number of elements to reduce.
- cmd_sub_n  in  1  1: result = e0+e1+…; 0: result = e0−e1−e2−….
- in_valid  in  1  element offered.
- in_ready  out  1  element accepted when in_valid && in_ready.
- in_data  in  OPERAND_WIDTH  element.
- add_en  out  1  drives FP_ADD_SUB en.
- add_lhs  out  OPERAND_WIDTH  drives FP_ADD_SUB _lhs; always equals acc.
- add_rhs  out  OPERAND_WIDTH  drives FP_ADD_SUB _rhs; always equals in_data.
- add_sub_n  out  1  drives FP_ADD_SUB sub_n; equals the latched sub_n.
- add_res  in  OPERAND_WIDTH  FP_ADD_SUB res, combinational in add_*.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed when res_valid && res_ready.
- res_data  out  OPERAND_WIDTH  reduction result; equals acc.
- busy  out  1  high in every state except IDLE.

## Operation
- Registers:
  - state
  - acc (OPERAND_WIDTH)
  - rem (LEN_W, elements still to accept)
  - sub_n_q
- States and transitions:
  - IDLE: cmd_ready=1. On cmd handshake, latch sub_n_q=cmd_sub_n and rem=cmd_len, and clear acc to 0. If cmd_len==0, go to DONE; otherwise go to FIRST.
  - FIRST: in_ready=1, add_en=0. On in handshake, acc<=in_data and rem<=rem−1. If rem==1, go to DONE; otherwise go to ACCUM.
  - ACCUM: in_ready=1, add_en=in_valid. On in handshake, acc<=add_res and rem<=rem−1. If rem==1, go to DONE. With no handshake, hold all state.
  - DONE: res_valid=1. On res handshake, go to IDLE. acc holds until the next command is accepted.
- cmd_ready, in_ready and res_valid are pure functions of state; no combinational path exists from any *_valid or *_ready input to them.
- in_ready is 0 in IDLE and DONE. Elements presented then are not consumed.
- The first element never passes through the adder, so the subtract form yields e0−e1−…, not 0−e0−….
- add_en is 0 outside ACCUM, so the adder output is don't-care there.
- Arithmetic (rounding, special values) is entirely FP_ADD_SUB's. This block never modifies operand bits.
- rem arithmetic is unsigned. It never wraps, because it is decremented only while rem≥1.

## Timing
- Reset values: state=IDLE, acc=0, rem=0, sub_n_q=1. Outputs at reset:
  - cmd_ready=1
  - in_ready=0
  - add_en=0
  - add_lhs=0
  - add_sub_n=1
  - res_valid=0
  - res_data=0
  - busy=0
- Reset asserted mid-command returns the block to IDLE asynchronously. The partial acc is discarded and no result is emitted.
- Throughput: with in_valid held high, one element is accepted per cycle. For N≥1 elements, res_valid rises the cycle after the Nth in handshake.
- Command-to-result latency with no stalls: N+1 cycles after the cmd handshake. For cmd_len==0 it is 1 cycle, with res_data=0.
- res_valid stays high and res_data stays stable until res_ready. Back-pressure of any length is allowed.
- Minimum spacing is one IDLE cycle between the res handshake and the next cmd_ready.
- in_valid may drop in any cycle. FIRST and ACCUM simply wait, and add_en follows in_valid in ACCUM.

## Test plan
OPERAND_WIDTH=32, IEEE fp32 encodings, bound to the codebase FP_ADD_SUB.
- Reset: drive rst_n=0 mid-ACCUM, then release -> all outputs at their reset values the same cycle; next command behaves normally.
- Sum: len=3, sub_n=1, elements 0x3F800000, 0x40000000, 0x40400000 streamed back-to-back -> res_data=0x40C00000; res_valid 4 cycles after the cmd handshake.
- Subtract: len=3, sub_n=0, elements 0x40C00000, 0x40000000, 0x40400000 -> res_data=0x3F800000.
- Edge lengths:
  - len=1 with element 0xC0A00000 -> res_data=0xC0A00000, add_en never asserted.
  - len=0 -> res_data=0, in_ready never high, res_valid 1 cycle after the cmd.
- Stalls: len=4 of 0x3F800000, in_valid toggled randomly, res_ready held low for 5 cycles -> res_data=0x40800000, held stable; in_ready=0 and cmd_ready=0 throughout DONE.
- Back-to-back commands: second cmd_valid held high during the first command -> it is accepted only in IDLE after the first res handshake; both results are correct and in order.

Source files
------------

// File: rtl/vpu_fp_reduce_ctrl.sv
// ----------------------------------------------------------------------------
// vpu_fp_reduce_ctrl
//
// Reduces a stream of floating-point elements into a single result by
// time-sharing one external combinational FP adder/subtractor. Each command
// returns exactly one result. The command sets the element count and the
// mode: a sum (e0+e1+...) or first-minus-rest (e0-e1-e2-...).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (cmd_len, cmd_sub_n)
//   in_valid/in_ready     element handshake (in_data), one per cycle max
//   add_en/add_lhs/add_rhs/add_sub_n  drive the shared adder
//   add_res               combinational adder result
//   res_valid/res_ready   result handshake (res_data)
//   busy                  high whenever a command is in flight
//
// The three handshake "ready/valid" outputs decode only the state register.
// No input reaches them combinationally.
// ----------------------------------------------------------------------------
module vpu_fp_reduce_ctrl #(
    parameter int OPERAND_WIDTH = 32,
    parameter int LEN_W         = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [LEN_W-1:0]         cmd_len,
    input  logic                     cmd_sub_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPERAND_WIDTH-1:0] in_data,
    output logic                     add_en,
    output logic [OPERAND_WIDTH-1:0] add_lhs,
    output logic [OPERAND_WIDTH-1:0] add_rhs,
    output logic                     add_sub_n,
    input  logic [OPERAND_WIDTH-1:0] add_res,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [OPERAND_WIDTH-1:0] res_data,
    output logic                     busy
);

    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_ACCUM = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e                   state_r;
    state_e                   state_nxt_s;
    logic [OPERAND_WIDTH-1:0] acc_r;
    logic [OPERAND_WIDTH-1:0] acc_nxt_s;
    logic [LEN_W-1:0]         rem_r;
    logic [LEN_W-1:0]         rem_nxt_s;
    logic                     sub_n_r;
    logic                     sub_n_nxt_s;
    logic                     cmd_ready_s;
    logic                     in_ready_s;
    logic                     res_valid_s;
    logic                     add_en_s;

    // State, accumulator, remaining-count and mode registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            acc_r   <= {OPERAND_WIDTH{1'b0}};
            rem_r   <= LEN_ZERO;
            sub_n_r <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            acc_r   <= acc_nxt_s;
            rem_r   <= rem_nxt_s;
            sub_n_r <= sub_n_nxt_s;
        end
    end

    // Next-state, datapath update and state-decoded handshake outputs
    always_comb begin
        state_nxt_s = state_r;
        acc_nxt_s   = acc_r;
        rem_nxt_s   = rem_r;
        sub_n_nxt_s = sub_n_r;
        cmd_ready_s = 1'b0;
        in_ready_s  = 1'b0;
        res_valid_s = 1'b0;
        add_en_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                cmd_ready_s = 1'b1;
                if (cmd_valid) begin
                    sub_n_nxt_s = cmd_sub_n;
                    rem_nxt_s   = cmd_len;
                    acc_nxt_s   = {OPERAND_WIDTH{1'b0}};
                    // An empty reduction goes straight to DONE with a zero result
                    if (cmd_len == LEN_ZERO) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_FIRST;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            // The first element bypasses the adder so that subtract mode
            // yields e0-e1-... instead of 0-e0-e1-...
            ST_FIRST: begin
                in_ready_s = 1'b1;
                if (in_valid) begin
                    acc_nxt_s = in_data;
                    rem_nxt_s = rem_r - LEN_ONE;
                    if (rem_r == LEN_ONE) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_ACCUM;
                    end
                end else begin
                    state_nxt_s = ST_FIRST;
                end
            end

            ST_ACCUM: begin
                in_ready_s = 1'b1;
                add_en_s   = in_valid;
                if (in_valid) begin
                    acc_nxt_s = add_res;
                    rem_nxt_s = rem_r - LEN_ONE;
                    if (rem_r == LEN_ONE) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_ACCUM;
                    end
                end else begin
                    state_nxt_s = ST_ACCUM;
                end
            end

            // acc is left untouched here so the result stays stable under
            // back-pressure and after the handshake until the next command.
            ST_DONE: begin
                res_valid_s = 1'b1;
                if (res_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end

            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready = cmd_ready_s;
    assign in_ready  = in_ready_s;
    assign res_valid = res_valid_s;
    assign add_en    = add_en_s;
    assign add_lhs   = acc_r;
    assign add_rhs   = in_data;
    assign add_sub_n = sub_n_r;
    assign res_data  = acc_r;
    assign busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_vpu_fp_reduce_ctrl.sv
// ----------------------------------------------------------------------------
// Self-checking bench for vpu_fp_reduce_ctrl. It uses fp32 operands. A small
// real-arithmetic model stands in for the shared adder. Expected results are
// pushed on command acceptance and popped on each result handshake.
// ----------------------------------------------------------------------------
module tb_vpu_fp_reduce_ctrl;

    localparam int W  = 32;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [LW-1:0] cmd_len;
    logic          cmd_sub_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          add_en;
    logic [W-1:0]  add_lhs;
    logic [W-1:0]  add_rhs;
    logic          add_sub_n;
    logic [W-1:0]  add_res;
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  res_data;
    logic          busy;

    vpu_fp_reduce_ctrl #(.OPERAND_WIDTH(W), .LEN_W(LW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .cmd_sub_n (cmd_sub_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .add_en    (add_en),
        .add_lhs   (add_lhs),
        .add_rhs   (add_rhs),
        .add_sub_n (add_sub_n),
        .add_res   (add_res),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // fp32 <-> real conversion for normal numbers and zero (all that is used here)
    function automatic real fp32_to_real(logic [31:0] f);
        logic [63:0] b;
        if (f[30:0] == 31'd0) begin
            b = {f[31], 63'd0};
        end else begin
            b = {f[31], 11'({3'd0, f[30:23]} + 11'd896), f[22:0], 29'd0};
        end
        return $bitstoreal(b);
    endfunction

    function automatic logic [31:0] real_to_fp32(real r);
        logic [63:0] b;
        b = $realtobits(r);
        if (b[62:0] == 63'd0) begin
            return {b[63], 31'd0};
        end
        return {b[63], 8'(b[62:52] - 11'd896), b[51:29]};
    endfunction

    // Stand-in for the shared combinational adder/subtractor
    always_comb begin
        if (add_sub_n) begin
            add_res = real_to_fp32(fp32_to_real(add_lhs) + fp32_to_real(add_rhs));
        end else begin
            add_res = real_to_fp32(fp32_to_real(add_lhs) - fp32_to_real(add_rhs));
        end
    end

    int          n_checks  = 0;
    int          n_errors  = 0;
    int          n_results = 0;
    logic [31:0] exp_q[$];
    logic [31:0] elem_buf [0:7];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard: compare every result handshake against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            int pend;
            pend = exp_q.size();
            check_val("res_pending", 32'(pend > 0), 32'd1);
            if (pend > 0) begin
                check_val("res_data", res_data, exp_q.pop_front());
            end
            n_results++;
        end
    end

    task automatic check_reset_outputs(input string pfx);
        check_val({pfx, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check_val({pfx, "_in_ready"},  32'(in_ready),  32'd0);
        check_val({pfx, "_add_en"},    32'(add_en),    32'd0);
        check_val({pfx, "_add_lhs"},   add_lhs,        32'd0);
        check_val({pfx, "_add_sub_n"}, 32'(add_sub_n), 32'd1);
        check_val({pfx, "_res_valid"}, 32'(res_valid), 32'd0);
        check_val({pfx, "_res_data"},  res_data,       32'd0);
        check_val({pfx, "_busy"},      32'(busy),      32'd0);
    endtask

    // Offer a command and wait for acceptance; leaves the bench just after the accepting edge
    task automatic issue_cmd(input logic [LW-1:0] len, input logic sub_n, input logic [31:0] exp,
                             input bit expect_drained);
        bit accepted;
        accepted  = 1'b0;
        cmd_valid = 1'b1;
        cmd_len   = len;
        cmd_sub_n = sub_n;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                accepted = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check_val("cmd_accepted", 32'(accepted), 32'd1);
        if (expect_drained) begin
            check_val("b2b_prev_drained", 32'(exp_q.size()), 32'd0);
            check_val("b2b_idle_gap", 32'(busy), 32'd0);
        end
        exp_q.push_back(exp);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Stream the elements, then wait through res_ready back-pressure and consume the result
    task automatic run_body(input int len, input bit stall, input int hold, input logic [31:0] exp);
        int          idx;
        int          cyc;
        int          lat;
        bit          done;
        bit          saw_add_en;
        bit          saw_in_ready;
        bit          saw_cmd_ready;
        logic [31:0] first_val;
        idx = 0; cyc = 1; lat = 0; done = 1'b0;
        saw_add_en = 1'b0; saw_in_ready = 1'b0; saw_cmd_ready = 1'b0;
        for (int k = 0; k < 200; k++) begin
            in_valid = (idx < len) && (stall ? 1'($urandom_range(0, 1)) : 1'b1);
            in_data  = (idx < 8) ? elem_buf[idx] : 32'd0;
            @(negedge clk);
            if (add_en)    saw_add_en    = 1'b1;
            if (in_ready)  saw_in_ready  = 1'b1;
            if (cmd_ready) saw_cmd_ready = 1'b1;
            if (res_valid) begin
                lat  = cyc;
                done = 1'b1;
                break;
            end
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        check_val("body_done", 32'(done), 32'd1);
        check_val("elems_taken", 32'(idx), 32'(len));
        check_val("cmd_ready_busy", 32'(saw_cmd_ready), 32'd0);
        if (!stall) check_val("latency", 32'(lat), 32'(len + 1));
        if (len <= 1) check_val("add_en_never", 32'(saw_add_en), 32'd0);
        if (len == 0) check_val("in_ready_never", 32'(saw_in_ready), 32'd0);
        check_val("done_in_ready", 32'(in_ready), 32'd0);
        check_val("done_cmd_ready", 32'(cmd_ready), 32'd0);
        first_val = res_data;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            @(negedge clk);
            check_val("hold_valid", 32'(res_valid), 32'd1);
            check_val("hold_stable", res_data, first_val);
            check_val("hold_data", res_data, exp);
            check_val("hold_in_ready", 32'(in_ready), 32'd0);
            check_val("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0; cmd_sub_n = 1'b1;
        in_valid = 1'b0; in_data = 32'd0; res_ready = 1'b0;
        for (int i = 0; i < 8; i++) elem_buf[i] = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_rst");
        @(posedge clk); #1;

        // Reset asserted in the middle of an accumulation
        issue_cmd(8'd4, 1'b1, 32'h40800000, 1'b0);
        in_valid = 1'b1; in_data = 32'h3F800000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("pre_reset_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_rst");
        in_valid = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Sum 1+2+3
        elem_buf[0] = 32'h3F800000; elem_buf[1] = 32'h40000000; elem_buf[2] = 32'h40400000;
        issue_cmd(8'd3, 1'b1, 32'h40C00000, 1'b0);
        run_body(3, 1'b0, 0, 32'h40C00000);

        // Subtract 6-2-3
        elem_buf[0] = 32'h40C00000; elem_buf[1] = 32'h40000000; elem_buf[2] = 32'h40400000;
        issue_cmd(8'd3, 1'b0, 32'h3F800000, 1'b0);
        run_body(3, 1'b0, 0, 32'h3F800000);

        // Single element passes through untouched
        elem_buf[0] = 32'hC0A00000;
        issue_cmd(8'd1, 1'b0, 32'hC0A00000, 1'b0);
        run_body(1, 1'b0, 0, 32'hC0A00000);

        // Empty reduction
        issue_cmd(8'd0, 1'b1, 32'h00000000, 1'b0);
        run_body(0, 1'b0, 2, 32'h00000000);

        // Random input stalls plus result back-pressure
        for (int i = 0; i < 4; i++) elem_buf[i] = 32'h3F800000;
        issue_cmd(8'd4, 1'b1, 32'h40800000, 1'b0);
        run_body(4, 1'b1, 5, 32'h40800000);

        // Back-to-back: second command offered while the first is in flight
        elem_buf[0] = 32'h3F800000; elem_buf[1] = 32'h40000000; elem_buf[2] = 32'h40400000;
        issue_cmd(8'd3, 1'b1, 32'h40C00000, 1'b0);
        cmd_valid = 1'b1; cmd_len = 8'd2; cmd_sub_n = 1'b0;
        run_body(3, 1'b0, 0, 32'h40C00000);
        elem_buf[0] = 32'h40A00000; elem_buf[1] = 32'h40000000;
        issue_cmd(8'd2, 1'b0, 32'h40400000, 1'b1);
        run_body(2, 1'b0, 0, 32'h40400000);

        repeat (2) @(posedge clk);
        #1;
        check_val("result_count", 32'(n_results), 32'd7);
        check_val("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
